// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// WIDTH of any seq_divider instance must not exceed MAX_WIDTH.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  localparam int DEFAULT_WIDTH = 32;
  localparam int MAX_WIDTH     = 64;

  localparam logic [MAX_WIDTH-1:0] DIV0_QUOTIENT = '1;

  // Two's-complement magnitude of the low w bits of x; bits above w are cleared.
  function automatic logic [MAX_WIDTH-1:0] twos_mag(input logic [MAX_WIDTH-1:0] x,
                                                    input int unsigned w);
    logic [MAX_WIDTH-1:0] mask;
    logic [MAX_WIDTH-1:0] neg;
    if (w >= MAX_WIDTH) begin
      mask = '1;
    end else begin
      mask = (MAX_WIDTH'(1) << w) - MAX_WIDTH'(1);
    end
    neg = (~x) + MAX_WIDTH'(1);
    return (x[w-1] ? neg : x) & mask;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// try to subtract the divisor magnitude, and record the outcome as a quotient bit.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_qreg,
  input  logic [WIDTH-1:0] i_dmag,
  output logic [WIDTH:0]   o_rem_next,
  output logic [WIDTH-1:0] o_qreg_next
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;
  logic           w_fits;

  assign w_shift = {i_rem[WIDTH-1:0], i_qreg[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, i_dmag};
  // A set top remainder bit means the shifted value already exceeds any divisor.
  assign w_fits  = i_rem[WIDTH] | (w_shift >= {1'b0, i_dmag});

  assign o_rem_next  = w_fits ? w_trial : w_shift;
  assign o_qreg_next = {i_qreg[WIDTH-2:0], w_fits};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, start/done handshake.
// Define SEQ_DIV_SIGNED_EN for two's-complement signed operands; default is unsigned.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e       r_state;
  div_state_e       w_state_next;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_qreg;
  logic [WIDTH-1:0] r_dmag;
  logic [CW-1:0]    r_count;
  logic             r_div0;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_done;
  logic             r_div_by_zero;

  logic             w_accept;
  logic             w_div0;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_rem_next;
  logic [WIDTH-1:0] w_qreg_next;
  logic [WIDTH-1:0] w_quot_fixed;
  logic [WIDTH-1:0] w_rem_fixed;

  assign w_div0 = (divisor == '0);

`ifdef SEQ_DIV_SIGNED_EN
  logic r_q_neg;
  logic r_r_neg;

  assign w_dvd_mag    = WIDTH'(twos_mag(MAX_WIDTH'(dividend), WIDTH));
  assign w_dvs_mag    = WIDTH'(twos_mag(MAX_WIDTH'(divisor), WIDTH));
  assign w_quot_fixed = r_q_neg ? -r_qreg : r_qreg;
  assign w_rem_fixed  = r_r_neg ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
    end else if (w_accept) begin
      r_q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_r_neg <= dividend[WIDTH-1];
    end
  end
`else
  assign w_dvd_mag    = dividend;
  assign w_dvs_mag    = divisor;
  assign w_quot_fixed = r_qreg;
  assign w_rem_fixed  = r_rem[WIDTH-1:0];
`endif

  div_restore_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem       (r_rem),
    .i_qreg      (r_qreg),
    .i_dmag      (r_dmag),
    .o_rem_next  (w_rem_next),
    .o_qreg_next (w_qreg_next)
  );

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = w_div0 ? FIX : ITER;
        end
      end
      ITER: begin
        if (r_count == CW'(1)) begin
          w_state_next = FIX;
        end
      end
      FIX: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_rem         <= '0;
      r_qreg        <= '0;
      r_dmag        <= '0;
      r_count       <= '0;
      r_div0        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rem         <= '0;
            r_count       <= CW'(WIDTH);
            r_dmag        <= w_dvs_mag;
            // On divide-by-zero the raw dividend is parked here to become the remainder.
            r_qreg        <= w_div0 ? dividend : w_dvd_mag;
            r_div0        <= w_div0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
          end
        end
        ITER: begin
          r_rem   <= w_rem_next;
          r_qreg  <= w_qreg_next;
          r_count <= r_count - CW'(1);
        end
        FIX: begin
          r_done <= 1'b1;
          if (r_div0) begin
            r_quotient    <= WIDTH'(DIV0_QUOTIENT);
            r_remainder   <= r_qreg;
            r_div_by_zero <= 1'b1;
          end else begin
            r_quotient  <= w_quot_fixed;
            r_remainder <= w_rem_fixed;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=32), hand-computed expected results,
// covering both the unsigned default build and the SEQ_DIV_SIGNED_EN build.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_divider #(
    .WIDTH (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation; optionally pulses start with other operands at iteration pulse_at.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz,
                       input int elat, input int pulse_at);
    int   n;
    logic seen;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, ".busy_after_start"}, 64'(busy), 64'd1);
    n    = 0;
    seen = 1'b0;
    while (n < 100 && !seen) begin
      if (pulse_at > 0 && n == pulse_at) begin
        @(negedge clk);
        dividend = 32'd200;
        divisor  = 32'd5;
        start    = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
      if (done) seen = 1'b1;
    end
    check({tag, ".latency"}, 64'(n), 64'(elat));
    check({tag, ".busy_at_done"}, 64'(busy), 64'd0);
    check({tag, ".quotient"}, 64'(quotient), 64'(eq));
    check({tag, ".remainder"}, 64'(remainder), 64'(er));
    check({tag, ".div_by_zero"}, 64'(div_by_zero), 64'(edz));
    $display("op %s: %0h / %0h -> q=%0h r=%0h dz=%0b cycles=%0d",
             tag, a, b, quotient, remainder, div_by_zero, n);
    @(posedge clk);
    #1;
    check({tag, ".done_one_cycle"}, 64'(done), 64'd0);
    check({tag, ".quotient_held"}, 64'(quotient), 64'(eq));
    check({tag, ".dz_held"}, 64'(div_by_zero), 64'(edz));
  endtask

  initial begin
    int n;
    int d1;
    int d2;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.quotient", 64'(quotient), 64'd0);
    check("reset.remainder", 64'(remainder), 64'd0);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.dz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 0);
    do_op("5_0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 0);
    do_op("9_3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, 0);
    do_op("7_7", 32'd7, 32'd7, 32'd1, 32'd0, 1'b0, 33, 0);
    do_op("3_10", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 33, 0);
    do_op("0_5", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 33, 0);
    do_op("123456789_1000", 32'd123456789, 32'd1000, 32'd123456, 32'd789, 1'b0, 33, 0);
    do_op("100_7_ignored_start", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 3);

`ifdef SEQ_DIV_SIGNED_EN
    do_op("m100_7", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33, 0);
    do_op("100_m7", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 33, 0);
    do_op("min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33, 0);
    do_op("m5_0", 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1, 0);
`else
    do_op("ffffffff_2", 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0, 33, 0);
    do_op("80000000_3", 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2, 1'b0, 33, 0);
`endif

    // Reset in the middle of an iteration, after an ignored start pulse.
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("midrst.busy_before", 64'(busy), 64'd1);
    check("midrst.done_before", 64'(done), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst.quotient", 64'(quotient), 64'd0);
    check("midrst.remainder", 64'(remainder), 64'd0);
    check("midrst.busy", 64'(busy), 64'd0);
    check("midrst.done", 64'(done), 64'd0);
    check("midrst.dz", 64'(div_by_zero), 64'd0);
    $display("op midrst: 1000 / 3 aborted by reset at iteration 10");
    @(negedge clk);
    rst = 1'b0;
    do_op("9_3_after_rst", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33, 0);

    // Start held high: two operations back to back.
    @(negedge clk);
`ifdef SEQ_DIV_SIGNED_EN
    dividend = 32'd1000;
    divisor  = 32'd3;
`else
    dividend = 32'hFFFF_FFFF;
    divisor  = 32'd2;
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    n  = 0;
    d1 = 0;
    d2 = 0;
    while (n < 200 && d2 == 0) begin
      @(posedge clk);
      #1;
      n++;
      if (done) begin
        if (d1 == 0) begin
          d1 = n;
`ifdef SEQ_DIV_SIGNED_EN
          check("b2b.first_quotient", 64'(quotient), 64'd333);
`else
          check("b2b.first_quotient", 64'(quotient), 64'h7FFF_FFFF);
`endif
          check("b2b.first_remainder", 64'(remainder), 64'd1);
        end else begin
          d2 = n;
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    check("b2b.first_latency", 64'(d1), 64'd33);
    check("b2b.spacing", 64'(d2 - d1), 64'd34);
`ifdef SEQ_DIV_SIGNED_EN
    check("b2b.second_quotient", 64'(quotient), 64'd333);
`else
    check("b2b.second_quotient", 64'(quotient), 64'h7FFF_FFFF);
`endif
    check("b2b.second_remainder", 64'(remainder), 64'd1);
    $display("op b2b: done pulses after edges %0d and %0d", d1, d2);
    repeat (3) @(posedge clk);
    #1;
    check("b2b.idle_after_release", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
